// File: rtl/div_pkg.sv
// Shared types for the sequential divider.
//   div_state_t   : controller state encoding (IDLE, RUN, ZERO, DONE)
//   div_cnt_width : width of the iteration counter for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // The counter must hold the value WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for the restoring divider.
// Computes i_a - i_b as i_a + ~i_b + 1 on a ripple chain of full-adder cells.
// Ports:
//   i_a      [N-1:0]  minuend (shifted partial remainder)
//   i_b      [N-1:0]  subtrahend (zero-extended divisor)
//   o_diff   [N-1:0]  i_a - i_b modulo 2^N
//   o_borrow          1 when i_a < i_b (inverted carry-out of the chain)

// One-bit full-adder cell used to build the ripple chain.
// Ports: i_a, i_b, i_cin in; o_sum, o_cout out.
module div_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_sum  = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);
endmodule

module div_trial_sub #(
  parameter int N = 65
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_borrow
);
  logic [N:0] w_c;

  // Carry-in of 1 completes the two's-complement negation of i_b.
  assign w_c[0] = 1'b1;

  for (genvar g = 0; g < N; g++) begin : g_fa
    div_full_adder u_fa (
      .i_a    (i_a[g]),
      .i_b    (~i_b[g]),
      .i_cin  (w_c[g]),
      .o_sum  (o_diff[g]),
      .o_cout (w_c[g+1])
    );
  end

  assign o_borrow = ~w_c[N];
endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   start                  request, accepted in IDLE or DONE
//   dividend, divisor      [WIDTH-1:0] operands, sampled on the accepting edge
//   busy                   high in RUN and ZERO
//   done                   one-cycle pulse in DONE; results valid from then
//   quotient, remainder    [WIDTH-1:0] results, held until the next op completes
//   div_by_zero            set alongside done when divisor was 0, held likewise
//
// Handshake: start is taken on a rising edge whenever busy is low (IDLE or
// DONE); the operands are captured on that same edge and busy rises for the
// following cycle. While busy is high start is ignored. done pulses for
// exactly one cycle, WIDTH+1 cycles after acceptance (2 for a zero divisor).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = div_cnt_width(WIDTH);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic             w_accept;
  logic             w_last;
  logic             w_busy;
  logic             w_done;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic             w_keep;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;

  // Datapath: shift the next dividend bit into the partial remainder and try
  // to subtract the divisor over WIDTH+1 bits.
  assign w_shift = {r_r, r_q[WIDTH-1]};

  div_trial_sub #(.N(WIDTH + 1)) u_sub (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_d}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // Without a borrow the difference is below the divisor, so its top bit is
  // always 0; a set top bit can only accompany a borrow. Folding it into the
  // restore decision lets the working remainder stay WIDTH bits wide.
  assign w_keep   = w_borrow | w_diff[WIDTH];
  assign w_r_next = w_keep ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_q_next = {r_q[WIDTH-2:0], ~w_keep};

  // Controller next-state and outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = (divisor == '0) ? ZERO : RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      ZERO: begin
        w_busy       = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = (divisor == '0) ? ZERO : RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_r    <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_q   <= dividend;
        r_d   <= divisor;
        r_r   <= '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_q   <= w_q_next;
        r_r   <= w_r_next;
        r_cnt <= r_cnt + CW'(1);
      end

      // Results change only on the edge that enters DONE.
      if (w_last) begin
        r_quot <= w_q_next;
        r_rem  <= w_r_next;
        r_dbz  <= 1'b0;
      end else if (r_state == ZERO) begin
        r_quot <= '1;
        r_rem  <= r_q;
        r_dbz  <= 1'b1;
      end
    end
  end

  assign busy        = w_busy;
  assign done        = w_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: one 8-bit and one 64-bit instance side by side.
// A cycle-level model predicts busy/done/results from arithmetic division and
// a schedule of when each accepted operation must finish.
module tb_seq_divider;

  logic clk;
  logic rst [2];
  logic st  [2];
  logic [63:0] nn [2];
  logic [63:0] dd [2];

  logic       busy8, done8, z8;
  logic [7:0] q8, r8;
  logic        busy64, done64, z64;
  logic [63:0] q64, r64;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;
  bit fin8    = 0;
  bit fin64   = 0;

  // model state, index 0 = 8-bit instance, 1 = 64-bit instance
  bit          m_init     [2];
  bit          m_active   [2];
  int          m_done_edge[2];
  logic [63:0] m_q [2];
  logic [63:0] m_r [2];
  logic        m_z [2];
  logic [63:0] p_q [2];
  logic [63:0] p_r [2];
  logic        p_z [2];

  seq_divider #(.WIDTH(8)) u_d8 (
    .clk         (clk),
    .reset       (rst[0]),
    .start       (st[0]),
    .dividend    (nn[0][7:0]),
    .divisor     (dd[0][7:0]),
    .busy        (busy8),
    .done        (done8),
    .quotient    (q8),
    .remainder   (r8),
    .div_by_zero (z8)
  );

  seq_divider #(.WIDTH(64)) u_d64 (
    .clk         (clk),
    .reset       (rst[1]),
    .start       (st[1]),
    .dividend    (nn[1]),
    .divisor     (dd[1]),
    .busy        (busy64),
    .done        (done64),
    .quotient    (q64),
    .remainder   (r64),
    .div_by_zero (z64)
  );

  // clock / reset defaults
  initial begin
    clk = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; st[i] = 1'b0; nn[i] = '0; dd[i] = '0;
      m_init[i] = 0; m_active[i] = 0; m_done_edge[i] = 0;
      m_q[i] = '0; m_r[i] = '0; m_z[i] = 1'b0;
      p_q[i] = '0; p_r[i] = '0; p_z[i] = 1'b0;
    end
  end
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: on acceptance the result is fixed by arithmetic, and the edge on
  // which it appears is acceptance + WIDTH (or +1 for a zero divisor).
  always @(posedge clk) begin
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      logic [63:0] mask, n, d;
      int w;
      w    = (i == 0) ? 8 : 64;
      mask = (i == 0) ? 64'hFF : '1;
      if (rst[i]) begin
        m_init[i] = 1; m_active[i] = 0;
        m_q[i] = '0; m_r[i] = '0; m_z[i] = 1'b0;
      end else if (m_init[i]) begin
        if (m_active[i] && ecnt == m_done_edge[i]) begin
          m_q[i] = p_q[i]; m_r[i] = p_r[i]; m_z[i] = p_z[i];
        end
        if (st[i] && !(m_active[i] && (ecnt - 1) < m_done_edge[i])) begin
          n = nn[i] & mask;
          d = dd[i] & mask;
          if (d == 0) begin
            p_q[i] = mask; p_r[i] = n; p_z[i] = 1'b1;
            m_done_edge[i] = ecnt + 1;
          end else begin
            p_q[i] = n / d; p_r[i] = n % d; p_z[i] = 1'b0;
            m_done_edge[i] = ecnt + w;
          end
          m_active[i] = 1;
        end
      end
    end
  end

  task automatic cmp(input int i, input logic b, input logic dn,
                     input logic [63:0] q, input logic [63:0] r, input logic z);
    logic eb, ed;
    int   w;
    w  = (i == 0) ? 8 : 64;
    eb = m_active[i] && (ecnt < m_done_edge[i]);
    ed = m_active[i] && (ecnt == m_done_edge[i]);
    chk($sformatf("w%0d e%0d busy", w, ecnt), {63'b0, b}, {63'b0, eb});
    chk($sformatf("w%0d e%0d done", w, ecnt), {63'b0, dn}, {63'b0, ed});
    chk($sformatf("w%0d e%0d quotient", w, ecnt), q, m_q[i]);
    chk($sformatf("w%0d e%0d remainder", w, ecnt), r, m_r[i]);
    chk($sformatf("w%0d e%0d div_by_zero", w, ecnt), {63'b0, z}, {63'b0, m_z[i]});
  endtask

  // compare process: every cycle once the model has seen reset
  always @(negedge clk) begin
    if (m_init[0]) cmp(0, busy8, done8, {56'b0, q8}, {56'b0, r8}, z8);
    if (m_init[1]) cmp(1, busy64, done64, q64, r64, z64);
  end

  // Issue one 8-bit op at the current negedge and wait for done; returns at
  // the negedge of the done cycle so a follow-up op lands in DONE.
  task automatic op8(input logic [7:0] n, input logic [7:0] d, input string nm,
                     input logic [7:0] eq, input logic [7:0] er, input logic ez,
                     input int elat, input int ebusy);
    int lat, nb;
    st[0] = 1'b1; nn[0] = {56'b0, n}; dd[0] = {56'b0, d};
    @(negedge clk);
    st[0] = 1'b0; nn[0] = 64'($urandom); dd[0] = 64'($urandom);
    lat = 1; nb = 0;
    while (lat < 200) begin
      if (done8 === 1'b1) break;
      if (busy8 === 1'b1) nb++;
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(elat));
    chk({nm, " busy cycles"}, 64'(nb), 64'(ebusy));
    chk({nm, " quotient"}, {56'b0, q8}, {56'b0, eq});
    chk({nm, " remainder"}, {56'b0, r8}, {56'b0, er});
    chk({nm, " div_by_zero"}, {63'b0, z8}, {63'b0, ez});
  endtask

  task automatic op64(input logic [63:0] n, input logic [63:0] d, input string nm);
    int lat;
    logic [127:0] prod;
    st[1] = 1'b1; nn[1] = n; dd[1] = d;
    @(negedge clk);
    st[1] = 1'b0; nn[1] = {$urandom, $urandom}; dd[1] = {$urandom, $urandom};
    lat = 1;
    while (lat < 300) begin
      if (done64 === 1'b1) break;
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd65);
    prod = 128'(q64) * 128'(d) + 128'(r64);
    chk({nm, " q*d+r==n"}, {63'b0, prod == {64'b0, n}}, 64'd1);
    chk({nm, " r<d"}, {63'b0, r64 < d}, 64'd1);
  endtask

  // 8-bit directed sequence
  initial begin
    int lat;
    bit saw;
    rst[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    chk("w8 reset busy", {63'b0, busy8}, 64'd0);
    chk("w8 reset done", {63'b0, done8}, 64'd0);
    chk("w8 reset quotient", {56'b0, q8}, 64'd0);
    chk("w8 reset remainder", {56'b0, r8}, 64'd0);
    chk("w8 reset div_by_zero", {63'b0, z8}, 64'd0);
    @(negedge clk);

    op8(8'd100, 8'd7,   "t1 100/7",   8'd14,  8'd2,   1'b0, 9, 8);
    @(negedge clk);
    op8(8'd255, 8'd0,   "t2 255/0",   8'hFF,  8'd255, 1'b1, 2, 1);
    @(negedge clk);
    op8(8'd200, 8'd201, "t3 200/201", 8'd0,   8'd200, 1'b0, 9, 8);
    op8(8'd255, 8'd128, "t3 255/128", 8'd1,   8'd127, 1'b0, 9, 8);
    op8(8'd123, 8'd1,   "b 123/1",    8'd123, 8'd0,   1'b0, 9, 8);
    op8(8'd77,  8'd77,  "b 77/77",    8'd1,   8'd0,   1'b0, 9, 8);
    op8(8'd255, 8'd1,   "b 255/1",    8'd255, 8'd0,   1'b0, 9, 8);
    @(negedge clk);

    // t4: start pulse while busy is ignored
    st[0] = 1'b1; nn[0] = 64'd100; dd[0] = 64'd7;
    @(negedge clk);
    st[0] = 1'b0; lat = 1;
    @(negedge clk); lat++;
    st[0] = 1'b1; nn[0] = 64'd9; dd[0] = 64'd3;
    @(negedge clk); lat++;
    st[0] = 1'b0; nn[0] = 64'($urandom); dd[0] = 64'($urandom);
    while (lat < 200) begin
      if (done8 === 1'b1) break;
      @(negedge clk);
      lat++;
    end
    chk("t4 latency", 64'(lat), 64'd9);
    chk("t4 quotient", {56'b0, q8}, 64'd14);
    chk("t4 remainder", {56'b0, r8}, 64'd2);
    op8(8'd9, 8'd3, "t4 9/3 in done", 8'd3, 8'd0, 1'b0, 9, 8);
    @(negedge clk);

    // t5: reset in the middle of a run
    st[0] = 1'b1; nn[0] = 64'd100; dd[0] = 64'd7;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("t5 busy", {63'b0, busy8}, 64'd0);
    chk("t5 done", {63'b0, done8}, 64'd0);
    chk("t5 quotient", {56'b0, q8}, 64'd0);
    chk("t5 remainder", {56'b0, r8}, 64'd0);
    chk("t5 div_by_zero", {63'b0, z8}, 64'd0);
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8 !== 1'b0) saw = 1;
    end
    chk("t5 no done", {63'b0, saw}, 64'd0);

    op8(8'd250, 8'd9, "post-reset 250/9", 8'd27, 8'd7, 1'b0, 9, 8);
    @(negedge clk);
    fin8 = 1;
  end

  // 64-bit random sequence
  initial begin
    logic [63:0] n, d;
    rst[1] = 1'b1;
    repeat (3) @(negedge clk);
    rst[1] = 1'b0;
    chk("w64 reset quotient", q64, 64'd0);
    chk("w64 reset remainder", r64, 64'd0);
    @(negedge clk);
    op64('1, 64'd1, "w64 ones/1");
    chk("w64 ones/1 quotient", q64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64 ones/1 remainder", r64, 64'd0);
    op64(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, "w64 msb divisor");
    chk("w64 msb quotient", q64, 64'd1);
    chk("w64 msb remainder", r64, 64'd1);
    for (int k = 0; k < 600; k++) begin
      n = {$urandom, $urandom};
      d = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (d == 0) d = 64'd1;
      op64(n, d, $sformatf("w64 rnd%0d", k));
    end
    @(negedge clk);
    fin64 = 1;
  end

  // final report
  initial begin
    fork
      wait (fin8 && fin64);
      begin
        #3000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected both sequences to finish");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
